// File: rtl/aqed_pkg.sv
// Shared FSM state encoding and default widths for the A-QED functional-consistency tracker.
package aqed_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ORIG = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } aqed_state_e;

    localparam int unsigned AQED_DATA_W = 16;
    localparam int unsigned AQED_CNT_W  = 16;

endpackage

// File: rtl/aqed_beat_cnt.sv
// Saturating beat counter: counts inc_i pulses and holds at all-ones, flagging sat_o.
// Latency: count visible the cycle after inc_i; no backpressure (pure observer).
module aqed_beat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/aqed_fc_tracker.sv
// A-QED tracker: maps chosen original/duplicate input beats to output beats, captures both, flags done/check.
// Latency: qed_done one cycle after the later capture; no backpressure (observer only).
module aqed_fc_tracker
    import aqed_pkg::*;
#(
    parameter int unsigned DATA_W   = AQED_DATA_W,
    parameter int unsigned CNT_W    = AQED_CNT_W,
    parameter bit          CHECK_IN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              orig_sel,
    input  logic              dup_sel,
    input  logic [DATA_W-1:0] out_data,
    input  logic              out_valid,
    input  logic [CNT_W-1:0]  cfg_offset,
    output logic              qed_done,
    output logic              qed_check,
    output logic [CNT_W-1:0]  orig_idx,
    output logic [CNT_W-1:0]  dup_idx,
    output logic              cnt_sat
);

    logic [CNT_W-1:0] in_cnt, out_cnt;
    logic             in_sat, out_sat;

    aqed_beat_cnt #(.CNT_W(CNT_W)) u_in_cnt (
        .clk_i(clk), .rst_n_i(reset), .inc_i(in_valid), .cnt_o(in_cnt), .sat_o(in_sat)
    );

    aqed_beat_cnt #(.CNT_W(CNT_W)) u_out_cnt (
        .clk_i(clk), .rst_n_i(reset), .inc_i(out_valid), .cnt_o(out_cnt), .sat_o(out_sat)
    );

    aqed_state_e      state_q, state_d;
    logic [CNT_W-1:0] orig_idx_q, orig_idx_d, dup_idx_q, dup_idx_d;
    logic [DATA_W-1:0] orig_in_q, orig_in_d, orig_out_q, orig_out_d, dup_out_q, dup_out_d;
    logic             orig_cap_q, orig_cap_d, dup_cap_q, dup_cap_d;
    logic             done_q, done_d, check_q, check_d, sat_q, sat_d;

    logic             frozen, in_match;
    logic [CNT_W-1:0] orig_tgt, dup_tgt;

    assign frozen   = sat_q | in_sat | out_sat;
    assign in_match = !CHECK_IN || (in_data == orig_in_q);
    assign orig_tgt = orig_idx_q - cfg_offset;
    assign dup_tgt  = dup_idx_q - cfg_offset;

    always_comb begin
        state_d    = state_q;
        orig_idx_d = orig_idx_q;
        dup_idx_d  = dup_idx_q;
        orig_in_d  = orig_in_q;
        orig_out_d = orig_out_q;
        dup_out_d  = dup_out_q;
        orig_cap_d = orig_cap_q;
        dup_cap_d  = dup_cap_q;
        done_d     = done_q;
        check_d    = check_q;
        sat_d      = sat_q;

        // Once a counter saturates before done, indices are no longer trustworthy: freeze.
        if (state_q != S_DONE) begin
            sat_d = frozen;
            if (!frozen) begin
                case (state_q)
                    S_IDLE: begin
                        if (in_valid && orig_sel && (in_cnt >= cfg_offset)) begin
                            orig_idx_d = in_cnt;
                            orig_in_d  = in_data;
                            state_d    = S_ORIG;
                        end
                    end
                    S_ORIG: begin
                        if (in_valid && dup_sel && in_match) begin
                            dup_idx_d = in_cnt;
                            state_d   = S_WAIT;
                        end
                    end
                    default: ;
                endcase

                if ((state_q == S_ORIG || state_q == S_WAIT) && out_valid && !orig_cap_q
                    && (out_cnt == orig_tgt)) begin
                    orig_out_d = out_data;
                    orig_cap_d = 1'b1;
                end
                if ((state_q == S_WAIT) && out_valid && !dup_cap_q && (out_cnt == dup_tgt)) begin
                    dup_out_d = out_data;
                    dup_cap_d = 1'b1;
                end

                // Decide on next-state captures so done rises right after the later capture.
                if ((state_q == S_WAIT) && orig_cap_d && dup_cap_d) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    check_d = (orig_out_d == dup_out_d);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            orig_idx_q <= '0;
            dup_idx_q  <= '0;
            orig_in_q  <= '0;
            orig_out_q <= '0;
            dup_out_q  <= '0;
            orig_cap_q <= 1'b0;
            dup_cap_q  <= 1'b0;
            done_q     <= 1'b0;
            check_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            orig_idx_q <= orig_idx_d;
            dup_idx_q  <= dup_idx_d;
            orig_in_q  <= orig_in_d;
            orig_out_q <= orig_out_d;
            dup_out_q  <= dup_out_d;
            orig_cap_q <= orig_cap_d;
            dup_cap_q  <= dup_cap_d;
            done_q     <= done_d;
            check_q    <= check_d;
            sat_q      <= sat_d;
        end
    end

    assign qed_done  = done_q;
    assign qed_check = check_q;
    assign orig_idx  = orig_idx_q;
    assign dup_idx   = dup_idx_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_aqed_fc_tracker.sv
// Bench for aqed_fc_tracker: directed and random streams against an index/time-level reference model.
module tb_aqed_fc_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] in_data, out_data, cfg_offset, orig_idx, dup_idx;
    logic        in_valid, orig_sel, dup_sel, out_valid;
    logic        qed_done, qed_check, cnt_sat;

    logic [15:0] s_in_data, s_out_data;
    logic        s_in_valid, s_orig_sel, s_dup_sel, s_out_valid;
    logic [2:0]  s_cfg, s_orig_idx, s_dup_idx;
    logic        s_done, s_check, s_sat;

    aqed_fc_tracker #(.DATA_W(16), .CNT_W(16), .CHECK_IN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .orig_sel(orig_sel), .dup_sel(dup_sel), .out_data(out_data), .out_valid(out_valid),
        .cfg_offset(cfg_offset), .qed_done(qed_done), .qed_check(qed_check),
        .orig_idx(orig_idx), .dup_idx(dup_idx), .cnt_sat(cnt_sat)
    );

    aqed_fc_tracker #(.DATA_W(16), .CNT_W(3), .CHECK_IN(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .in_data(s_in_data), .in_valid(s_in_valid),
        .orig_sel(s_orig_sel), .dup_sel(s_dup_sel), .out_data(s_out_data), .out_valid(s_out_valid),
        .cfg_offset(s_cfg), .qed_done(s_done), .qed_check(s_check),
        .orig_idx(s_orig_idx), .dup_idx(s_dup_idx), .cnt_sat(s_sat)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: which input beats were chosen, and what output values they map to.
    int          off, n_in, n_out, cyc;
    int          m_orig, m_dup;
    logic [15:0] m_orig_dat, m_ov, m_dv;
    bit          m_oc, m_dc;
    logic [15:0] outq[$];
    int          outq_t[$];
    int          corrupt_idx;
    logic [15:0] corrupt_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int offset);
        reset = 1'b0;
        in_valid = 0; in_data = '0; orig_sel = 0; dup_sel = 0; out_valid = 0; out_data = '0;
        s_in_valid = 0; s_in_data = '0; s_orig_sel = 0; s_dup_sel = 0; s_out_valid = 0; s_out_data = '0;
        s_cfg = '0;
        cfg_offset = 16'(offset);
        off = offset; n_in = 0; n_out = 0; cyc = 0;
        m_orig = -1; m_dup = -1; m_oc = 0; m_dc = 0; m_orig_dat = '0; m_ov = '0; m_dv = '0;
        outq.delete(); outq_t.delete();
        corrupt_idx = -1; corrupt_val = '0;
        #1;
        chk("rst_done", qed_done, 0);
        chk("rst_check", qed_check, 0);
        chk("rst_orig_idx", orig_idx, 0);
        chk("rst_dup_idx", dup_idx, 0);
        chk("rst_cnt_sat", cnt_sat, 0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // One clock: accelerator model emits outputs in order after a 1..3 cycle latency.
    task automatic cycle(input bit iv, input logic [15:0] id, input bit os, input bit ds);
        bit          ov;
        logic [15:0] od;
        ov = 0; od = '0;
        if (outq.size() > 0 && outq_t[0] <= cyc && $urandom_range(0, 3) != 0) begin
            ov = 1; od = outq.pop_front(); outq_t.delete(0);
        end
        in_valid = iv; in_data = id; orig_sel = os; dup_sel = ds; out_valid = ov; out_data = od;
        if (ov) begin
            if (m_orig >= 0 && !m_oc && n_out == m_orig - off) begin m_oc = 1; m_ov = od; end
            if (m_dup >= 0 && !m_dc && n_out == m_dup - off) begin m_dc = 1; m_dv = od; end
            n_out++;
        end
        if (iv) begin
            if (m_orig < 0) begin
                if (os && n_in >= off) begin m_orig = n_in; m_orig_dat = id; end
            end else if (m_dup < 0 && ds && id == m_orig_dat) begin
                m_dup = n_in;
            end
            if (n_in >= off) begin
                outq.push_back((n_in - off == corrupt_idx) ? corrupt_val : id);
                outq_t.push_back(cyc + int'($urandom_range(1, 3)));
            end
            n_in++;
        end
        @(posedge clk); #1;
        cyc++;
        chk("qed_done", qed_done, m_oc && m_dc);
        if (m_oc && m_dc) chk("qed_check", qed_check, m_ov == m_dv);
        chk("orig_idx", orig_idx, (m_orig >= 0) ? m_orig : 0);
        chk("dup_idx", dup_idx, (m_dup >= 0) ? m_dup : 0);
        chk("cnt_sat", cnt_sat, 0);
    endtask

    task automatic beat(input logic [15:0] d, input bit os, input bit ds);
        repeat ($urandom_range(0, 2)) cycle(0, '0, 0, 0);
        cycle(1, d, os, ds);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (outq.size() > 0 && guard < 500) begin
            cycle(0, '0, 0, 0);
            guard++;
        end
        repeat (3) cycle(0, '0, 0, 0);
    endtask

    task automatic sbeat(input bit iv, input logic [15:0] d, input bit os, input bit ds, input bit ov);
        s_in_valid = iv; s_in_data = d; s_orig_sel = os; s_dup_sel = ds;
        s_out_valid = ov; s_out_data = d;
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset(0);

        // Identity stream, matching data on beats 2 and 5.
        for (int i = 0; i < 10; i++)
            beat((i == 2 || i == 5) ? 16'h00AB : 16'(16'h0100 + i), i == 2, i == 5);
        drain();
        chk("t1_done", qed_done, 1);
        chk("t1_check", qed_check, 1);
        chk("t1_dup_idx", dup_idx, 5);

        // Same stream with output 5 corrupted.
        do_reset(0);
        corrupt_idx = 5; corrupt_val = 16'h00AC;
        for (int i = 0; i < 10; i++)
            beat((i == 2 || i == 5) ? 16'h00AB : 16'(16'h0100 + i), i == 2, i == 5);
        drain();
        chk("t2_done", qed_done, 1);
        chk("t2_check", qed_check, 0);

        // Warm-up offset 4: selection on beat 2 is ignored.
        do_reset(4);
        for (int i = 0; i < 12; i++) begin
            beat((i == 6 || i == 9) ? 16'h0055 : 16'(16'h0200 + i), i == 2 || i == 6, i == 9);
            if (i == 3) chk("t3_ignored", orig_idx, 0);
        end
        drain();
        chk("t3_orig_idx", orig_idx, 6);
        chk("t3_dup_idx", dup_idx, 9);
        chk("t3_done", qed_done, 1);
        chk("t3_check", qed_check, 1);

        // Input-equality gate on the duplicate.
        do_reset(0);
        beat(16'h0300, 0, 0);
        beat(16'h0022, 1, 0);
        beat(16'h0301, 0, 0);
        beat(16'h0011, 0, 1);
        chk("t4_dup_gated", dup_idx, 0);
        beat(16'h0302, 0, 0);
        beat(16'h0303, 0, 0);
        beat(16'h0022, 0, 1);
        drain();
        chk("t4_dup_idx", dup_idx, 6);
        chk("t4_done", qed_done, 1);

        // Both selects on one beat, then reset mid-operation.
        do_reset(0);
        for (int i = 0; i < 5; i++) beat(16'(16'h0400 + i), i == 3, i == 3);
        chk("t5_orig_idx", orig_idx, 3);
        chk("t5_dup_idx", dup_idx, 0);
        do_reset(0);
        beat(16'h0444, 1, 0);
        beat(16'h0445, 0, 0);
        beat(16'h0444, 0, 1);
        drain();
        chk("t5_post_done", qed_done, 1);
        chk("t5_post_dup", dup_idx, 2);

        // Random streams with random offset, small data alphabet and optional corruption.
        for (int r = 0; r < 6; r++) begin
            do_reset(int'($urandom_range(0, 5)));
            if ($urandom_range(0, 1) != 0) begin
                corrupt_idx = int'($urandom_range(0, 20)); corrupt_val = 16'hFFFF;
            end
            for (int i = 0; i < 40; i++)
                beat(16'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            drain();
        end

        // Narrow counter saturates before a duplicate is offered.
        do_reset(0);
        sbeat(1, 16'h0100, 0, 0, 0);
        sbeat(1, 16'h0077, 1, 0, 0);
        for (int i = 2; i < 6; i++) sbeat(1, 16'(16'h0100 + i), 0, 0, 1);
        chk("sat_pre", s_sat, 0);
        chk("sat_orig_idx", s_orig_idx, 1);
        sbeat(1, 16'h0106, 0, 0, 0);
        sbeat(0, '0, 0, 0, 0);
        sbeat(0, '0, 0, 0, 0);
        chk("sat_set", s_sat, 1);
        sbeat(1, 16'h0077, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            sbeat(0, 16'h0077, 0, 0, 1);
            chk("sat_no_done", s_done, 0);
        end
        chk("sat_dup_idx", s_dup_idx, 0);
        chk("sat_sticky", s_sat, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
